// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, imem req/rdy reads and a one-entry instruction buffer for decode.
// Optional build macro FETCH_INSTR_CNT_EN adds a saturating instr_cnt output counting consumed instructions.
module fetch_unit #(
  parameter int unsigned         PC_W     = 16,
  parameter logic [PC_W-1:0]     RESET_PC = {PC_W{1'b0}}
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_rdy,
  input  logic [15:0]     imem_rdata,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            stall,
  input  logic            halt,
  output logic [15:0]     instr,
  output logic            instr_valid,
  output logic [PC_W-1:0] instr_pc,
  output logic [PC_W-1:0] pc_plus2,
  output logic            halted
`ifdef FETCH_INSTR_CNT_EN
  ,
  output logic [31:0]     instr_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_FETCH  = 2'b01,
    ST_HALTED = 2'b10
  } state_e;

  localparam logic [PC_W-1:0] PC_STEP = {{(PC_W-2){1'b0}}, 2'b10};
  localparam logic [15:0]     NOP     = 16'h0800;

  state_e          state_r;
  state_e          next_state_s;
  logic [PC_W-1:0] fetch_pc_r;
  logic [15:0]     instr_r;
  logic            instr_valid_r;
  logic [PC_W-1:0] instr_pc_r;
  logic            consume_s;
  logic            hlt_s;
  logic            req_s;
  logic            fill_s;

  assign consume_s = instr_valid_r & ~stall;
  assign hlt_s     = halt & consume_s & ~redirect;
  // A redirect or accepted HALT kills the request; a stalled full buffer has nowhere to put data.
  assign req_s     = (state_r == ST_FETCH) & ~redirect & ~hlt_s & (~instr_valid_r | ~stall);
  assign fill_s    = req_s & imem_rdy;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic: HALTED is sticky until reset.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE:   next_state_s = ST_FETCH;
      ST_FETCH:  begin
        if (hlt_s) begin
          next_state_s = ST_HALTED;
        end else begin
          next_state_s = ST_FETCH;
        end
      end
      ST_HALTED: next_state_s = ST_HALTED;
      default:   next_state_s = ST_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    imem_req  = req_s;
    imem_addr = fetch_pc_r;
    halted    = (state_r == ST_HALTED);
  end

  // PC and instruction buffer; redirect wins over halt, fill and consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_r    <= RESET_PC;
      instr_r       <= NOP;
      instr_valid_r <= 1'b0;
      instr_pc_r    <= RESET_PC;
    end else if (redirect) begin
      fetch_pc_r    <= redirect_pc;
      instr_valid_r <= 1'b0;
    end else if (hlt_s) begin
      instr_valid_r <= 1'b0;
    end else if (fill_s) begin
      instr_r       <= imem_rdata;
      instr_pc_r    <= fetch_pc_r;
      instr_valid_r <= 1'b1;
      fetch_pc_r    <= fetch_pc_r + PC_STEP;
    end else if (consume_s) begin
      instr_valid_r <= 1'b0;
    end else begin
      instr_valid_r <= instr_valid_r;
    end
  end

  assign instr       = instr_r;
  assign instr_valid = instr_valid_r;
  assign instr_pc    = instr_pc_r;
  assign pc_plus2    = instr_pc_r + PC_STEP;

`ifdef FETCH_INSTR_CNT_EN
  logic [31:0] instr_cnt_r;

  // Saturating count of instructions handed to decode, HALT included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_cnt_r <= 32'd0;
    end else if (consume_s && (instr_cnt_r != 32'hFFFF_FFFF)) begin
      instr_cnt_r <= instr_cnt_r + 32'd1;
    end else begin
      instr_cnt_r <= instr_cnt_r;
    end
  end

  assign instr_cnt = instr_cnt_r;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: scoreboard of expected (pc, word) pairs pushed on fills, popped on consumes.
// Also covers the FETCH_INSTR_CNT_EN counter when that macro is defined.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rdy;
  logic [15:0] imem_rdata;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        stall;
  logic        halt;
  logic [15:0] instr;
  logic        instr_valid;
  logic [15:0] instr_pc;
  logic [15:0] pc_plus2;
  logic        halted;
`ifdef FETCH_INSTR_CNT_EN
  logic [31:0] instr_cnt;
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_consume = 0;
  logic        exp_halt;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  function automatic logic [15:0] memf(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  // Memory model answers whatever address is presented.
  assign imem_rdata = memf(imem_addr);

  fetch_unit #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdy(imem_rdy), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall), .halt(halt),
    .instr(instr), .instr_valid(instr_valid), .instr_pc(instr_pc), .pc_plus2(pc_plus2),
    .halted(halted)
`ifdef FETCH_INSTR_CNT_EN
    , .instr_cnt(instr_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check mid-cycle, scoreboard consumes, record an expected fill, advance past the edge.
  task automatic cycle(input logic e_req, input logic [15:0] e_addr, input logic e_valid,
                       input logic [15:0] e_ipc, input logic push);
    logic [31:0] ent;
    @(negedge clk);
    chk("imem_req", {31'd0, imem_req}, {31'd0, e_req});
    chk("imem_addr", {16'd0, imem_addr}, {16'd0, e_addr});
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, e_valid});
    chk("halted", {31'd0, halted}, {31'd0, exp_halt});
    if (e_valid) chk("instr_pc_hold", {16'd0, instr_pc}, {16'd0, e_ipc});
    if (instr_valid && !stall) begin
      n_consume++;
      if (sb.size() == 0) begin
        chk("sb_unexpected", 32'd1, 32'd0);
      end else begin
        ent = sb.pop_front();
        chk("sb_instr_pc", {16'd0, instr_pc}, {16'd0, ent[31:16]});
        chk("sb_instr", {16'd0, instr}, {16'd0, ent[15:0]});
        chk("sb_pc_plus2", {16'd0, pc_plus2}, {16'd0, ent[31:16] + 16'd2});
      end
    end
    if (push) sb.push_back({e_addr, memf(e_addr)});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; imem_rdy = 1'b1; redirect = 1'b0; redirect_pc = 16'h0000;
    stall = 1'b0; halt = 1'b0; exp_halt = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", {16'd0, instr}, 32'h0000_0800);
    chk("rst_instr_pc", {16'd0, instr_pc}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_pc_plus2", {16'd0, pc_plus2}, 32'd2);
`ifdef FETCH_INSTR_CNT_EN
    chk("rst_cnt", instr_cnt, 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;

    // IDLE cycle, then streaming fetch.
    cycle(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    cycle(1'b1, 16'h0000, 1'b0, 16'h0000, 1'b1);
    cycle(1'b1, 16'h0002, 1'b1, 16'h0000, 1'b1);
    cycle(1'b1, 16'h0004, 1'b1, 16'h0002, 1'b1);

    // Stall with a full buffer: no request, everything frozen.
    stall = 1'b1;
    repeat (3) cycle(1'b0, 16'h0006, 1'b1, 16'h0004, 1'b0);
    stall = 1'b0;
    cycle(1'b1, 16'h0006, 1'b1, 16'h0004, 1'b1);

    // Slow memory: request held stable until rdy.
    imem_rdy = 1'b0;
    cycle(1'b1, 16'h0008, 1'b1, 16'h0006, 1'b0);
    repeat (3) cycle(1'b1, 16'h0008, 1'b0, 16'h0000, 1'b0);
    imem_rdy = 1'b1;
    cycle(1'b1, 16'h0008, 1'b0, 16'h0000, 1'b1);
    cycle(1'b1, 16'h000A, 1'b1, 16'h0008, 1'b1);

    // Redirect coinciding with rdy: response discarded.
    redirect = 1'b1; redirect_pc = 16'h0040;
    cycle(1'b0, 16'h000C, 1'b1, 16'h000A, 1'b0);
    redirect = 1'b0;
    cycle(1'b1, 16'h0040, 1'b0, 16'h0000, 1'b1);
    cycle(1'b1, 16'h0042, 1'b1, 16'h0040, 1'b1);

    // HALT together with redirect: redirect wins, no halt.
    halt = 1'b1; redirect = 1'b1; redirect_pc = 16'h0080;
    cycle(1'b0, 16'h0044, 1'b1, 16'h0042, 1'b0);
    halt = 1'b0; redirect = 1'b0;
    cycle(1'b1, 16'h0080, 1'b0, 16'h0000, 1'b1);
    cycle(1'b1, 16'h0082, 1'b1, 16'h0080, 1'b1);

    // Redirect to the top of the address space; PC wraps to zero.
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    cycle(1'b0, 16'h0084, 1'b1, 16'h0082, 1'b0);
    redirect = 1'b0;
    cycle(1'b1, 16'hFFFE, 1'b0, 16'h0000, 1'b1);
    cycle(1'b1, 16'h0000, 1'b1, 16'hFFFE, 1'b1);

    // Accepted HALT: fetch stops for good.
    halt = 1'b1;
    cycle(1'b0, 16'h0002, 1'b1, 16'h0000, 1'b0);
    halt = 1'b0; exp_halt = 1'b1;
    repeat (3) cycle(1'b0, 16'h0002, 1'b0, 16'h0000, 1'b0);

    chk("sb_empty", sb.size(), 32'd0);
`ifdef FETCH_INSTR_CNT_EN
    chk("instr_cnt", instr_cnt, n_consume);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
